// File: rtl/gray_seq_monitor_pkg.sv
// gray_seq_monitor_pkg: shared FSM state type and good-run threshold
package gray_seq_monitor_pkg;
   typedef enum logic [1:0] {UNSYNC, SYNC, FAULT} state_t;
   localparam logic [1:0] GOOD_RUN = 2'd2;
endpackage

// File: rtl/gray_seq_monitor_if.sv
// gray_seq_monitor_if: Gray sample strobe in, decoded value and status out
interface gray_seq_monitor_if #(parameter int W = 4, parameter int CW = 8) ();
   logic en;
   logic [W-1:0] g;
   logic [W-1:0] bin;
   logic step;
   logic err;
   logic wrap;
   logic sync;
   logic [CW-1:0] err_cnt;
   modport master (output en, g, input bin, step, err, wrap, sync, err_cnt);
   modport slave (input en, g, output bin, step, err, wrap, sync, err_cnt);
endinterface

// File: rtl/gray_seq_monitor_gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary conversion, each bit is the XOR of all Gray bits at or above it
module gray_to_bin #(parameter int W = 4) (
   input logic [W-1:0] g,
   output logic [W-1:0] bin
);
   for (genvar i = 0; i < W; i++) begin : g_b
      assign bin[i] = ^g[W-1:i];
   end
endmodule

// File: rtl/gray_seq_monitor.sv
// gray_seq_monitor: checks a Gray-code counter advances by +1, flags errors and resyncs after two good steps
module gray_seq_monitor
   import gray_seq_monitor_pkg::*;
#(
   parameter int W = 4,
   parameter int CW = 8
) (
   input logic clk,
   input logic rst,
   gray_seq_monitor_if.slave bus
);
   state_t state, state_nx;
   logic [W-1:0] prev, sample;
   logic [1:0] good, good_nx;
   logic step_nx, err_nx, wrap_nx, same, inc, tracking;
   logic [CW-1:0] cnt_nx;
   gray_to_bin #(.W(W)) u_g2b (.g(bus.g), .bin(sample));
   assign same = sample == prev;
   assign inc = sample == prev + W'(1);
   assign tracking = bus.en && state != UNSYNC;
   always_ff @(posedge clk)
      state <= !rst ? UNSYNC : state_nx;
   always_comb begin
      state_nx = !bus.en ? state :
                 state == UNSYNC ? SYNC :
                 state == SYNC && (same || inc) ? SYNC :
                 inc && good + 2'd1 == GOOD_RUN ? SYNC : FAULT;
      good_nx = !tracking ? good :
                !(same || inc) ? 2'd0 :
                state == FAULT && inc ? good + 2'd1 : good;
   end
   always_comb begin
      step_nx = tracking && inc;
      wrap_nx = step_nx && prev == '1;
      err_nx = tracking && !same && !inc;
      cnt_nx = err_nx && bus.err_cnt != '1 ? bus.err_cnt + 1'b1 : bus.err_cnt;
   end
   always_ff @(posedge clk)
      if (!rst) begin
         prev <= '0;
         good <= '0;
         bus.step <= 1'b0;
         bus.err <= 1'b0;
         bus.wrap <= 1'b0;
         bus.err_cnt <= '0;
      end else begin
         good <= good_nx;
         bus.step <= step_nx;
         bus.err <= err_nx;
         bus.wrap <= wrap_nx;
         bus.err_cnt <= cnt_nx;
         if (bus.en) prev <= sample;
      end
   assign bus.bin = prev;
   assign bus.sync = state == SYNC;
endmodule
